// File: rtl/signal_delay_meter.sv
// Measures clk cycles between a start rising edge and a stop rising edge, with a timeout window.
// Define SIGNAL_DELAY_METER_AVG_EN to add a running mean of the last four measured delays.
module signal_delay_meter #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] window,
    output logic [CNT_W-1:0] delay_out,
    output logic             valid,
    output logic             timeout,
`ifdef SIGNAL_DELAY_METER_AVG_EN
    output logic [CNT_W-1:0] avg_out,
    output logic             avg_valid,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic             start_d;
    logic             stop_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] win_q;
    logic             start_rise;
    logic             stop_rise;

    assign start_rise = start & ~start_d;
    assign stop_rise  = stop & ~stop_d;

    // cnt holds the number of cycles elapsed since the start edge, so it reads N when stop arrives N cycles later
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            start_d   <= 1'b0;
            stop_d    <= 1'b0;
            cnt       <= '0;
            win_q     <= '0;
            delay_out <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            start_d <= start;
            stop_d  <= stop;
            valid   <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        if (stop_rise) begin
                            delay_out <= '0;
                            valid     <= 1'b1;
                            state     <= DONE;
                        end else begin
                            win_q <= window;
                            cnt   <= CNT_W'(1);
                            busy  <= 1'b1;
                            state <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (stop_rise) begin
                        delay_out <= cnt;
                        valid     <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else if (cnt >= win_q) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SIGNAL_DELAY_METER_AVG_EN
    logic [CNT_W-1:0] hist [4];
    logic [CNT_W+1:0] sum;
    logic [CNT_W+1:0] sum_next;
    logic [2:0]       fill;

    // Oldest entry is zero until the history is full, so subtracting it keeps the sum exact while filling
    assign sum_next = sum + (CNT_W+2)'(delay_out) - (CNT_W+2)'(hist[3]);

    always_ff @(posedge clk) begin
        if (reset) begin
            hist[0]   <= '0;
            hist[1]   <= '0;
            hist[2]   <= '0;
            hist[3]   <= '0;
            sum       <= '0;
            fill      <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (valid) begin
                hist[0] <= delay_out;
                hist[1] <= hist[0];
                hist[2] <= hist[1];
                hist[3] <= hist[2];
                sum     <= sum_next;
                if (fill != 3'd4) begin
                    fill <= fill + 3'd1;
                end
                if (fill >= 3'd3) begin
                    avg_out   <= sum_next[CNT_W+1:2];
                    avg_valid <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_signal_delay_meter.sv
// Directed table-driven bench for signal_delay_meter; averaging checks build only with SIGNAL_DELAY_METER_AVG_EN.
module tb_signal_delay_meter;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic [9:0] window;
    logic [9:0] delay_out;
    logic       valid;
    logic       timeout;
    logic       busy;
`ifdef SIGNAL_DELAY_METER_AVG_EN
    logic [9:0] avg_out;
    logic       avg_valid;
`endif

    signal_delay_meter #(.CNT_W(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .window    (window),
        .delay_out (delay_out),
        .valid     (valid),
        .timeout   (timeout),
`ifdef SIGNAL_DELAY_METER_AVG_EN
        .avg_out   (avg_out),
        .avg_valid (avg_valid),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int win;
        int stop_at;
        bit exp_valid;
        int exp_k;
        int exp_delay;
    } vec_t;

    vec_t vecs [9];
    int   n_vec;
    int   n_err;
    int   g_valid_cnt;
    int   g_to_cnt;
    int   g_event_k;
    int   g_busy_evt;
    int   g_busy_k1;
    int   g_avgv_cnt;
    int   g_avgv_k;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Cycle 0 carries the start edge; sample k is taken #1 after the edge that ends cycle k-1
    task automatic applyStimulus(input int win, input int stop_at, input int run_len, input bit stop_pre);
        start = 1'b0;
        stop  = stop_pre;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        g_valid_cnt = 0;
        g_to_cnt    = 0;
        g_event_k   = -1;
        g_busy_evt  = -1;
        g_busy_k1   = -1;
        g_avgv_cnt  = 0;
        g_avgv_k    = -1;
        start  = 1'b1;
        window = 10'(win);
        if (stop_at == 0) stop = 1'b1;
        for (int k = 1; k <= run_len; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) g_busy_k1 = int'(busy);
            if (valid) g_valid_cnt++;
            if (timeout) g_to_cnt++;
            if ((valid || timeout) && g_event_k < 0) begin
                g_event_k  = k;
                g_busy_evt = int'(busy);
            end
`ifdef SIGNAL_DELAY_METER_AVG_EN
            if (avg_valid) begin
                g_avgv_cnt++;
                if (g_avgv_k < 0) g_avgv_k = k;
            end
`endif
            if (k == stop_at) stop = 1'b1;
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        int v_cnt;
        int t_cnt;
        int ev_k;
        int ev_d;

        n_vec = 0;
        n_err = 0;
        vecs[0] = '{100,  37, 1'b1,  38,  37};
        vecs[1] = '{ 20,  -1, 1'b0,  21,  37};
        vecs[2] = '{ 50,   0, 1'b1,   1,   0};
        vecs[3] = '{  0,  -1, 1'b0,   2,   0};
        vecs[4] = '{  0,   1, 1'b1,   2,   1};
        vecs[5] = '{  5,   5, 1'b1,   6,   5};
        vecs[6] = '{  5,   6, 1'b0,   6,   5};
        vecs[7] = '{  1,  -1, 1'b0,   2,   5};
        vecs[8] = '{1023, 200, 1'b1, 201, 200};

        reset  = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        window = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("reset delay_out", int'(delay_out), 0);
        checkOutput("reset valid", int'(valid), 0);
        checkOutput("reset timeout", int'(timeout), 0);
        checkOutput("reset busy", int'(busy), 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].win, vecs[i].stop_at, vecs[i].exp_k + 2, 1'b0);
            checkOutput($sformatf("v%0d valid count", i), g_valid_cnt, vecs[i].exp_valid ? 1 : 0);
            checkOutput($sformatf("v%0d timeout count", i), g_to_cnt, vecs[i].exp_valid ? 0 : 1);
            checkOutput($sformatf("v%0d event cycle", i), g_event_k, vecs[i].exp_k);
            checkOutput($sformatf("v%0d delay_out", i), int'(delay_out), vecs[i].exp_delay);
            checkOutput($sformatf("v%0d busy at event", i), g_busy_evt, 0);
            checkOutput($sformatf("v%0d busy first cycle", i), g_busy_k1, (vecs[i].stop_at != 0) ? 1 : 0);
        end

        // Second start edge and a window change mid-count must not disturb the measurement
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        v_cnt = 0; t_cnt = 0; ev_k = -1;
        start  = 1'b1;
        window = 10'd100;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                v_cnt++;
                if (ev_k < 0) ev_k = k;
            end
            if (timeout) t_cnt++;
            if (k == 3) begin
                start  = 1'b0;
                window = 10'd2;
            end
            if (k == 5) start = 1'b1;
            if (k == 12) stop = 1'b1;
        end
        checkOutput("restart valid count", v_cnt, 1);
        checkOutput("restart timeout count", t_cnt, 0);
        checkOutput("restart event cycle", ev_k, 13);
        checkOutput("restart delay_out", int'(delay_out), 12);

        // Reset at cnt = 15, then start still high is seen as a fresh edge
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        start  = 1'b1;
        window = 10'd100;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("pre-reset busy", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid reset busy", int'(busy), 0);
        checkOutput("mid reset delay_out", int'(delay_out), 0);
        checkOutput("mid reset valid", int'(valid), 0);
        checkOutput("mid reset timeout", int'(timeout), 0);
        reset = 1'b0;
        v_cnt = 0; t_cnt = 0; ev_k = -1; ev_d = -1;
        for (int j = 1; j <= 7; j++) begin
            @(posedge clk);
            #1;
            if (j == 1) checkOutput("post-reset start busy", int'(busy), 1);
            if (valid) begin
                v_cnt++;
                if (ev_k < 0) begin
                    ev_k = j;
                    ev_d = int'(delay_out);
                end
            end
            if (timeout) t_cnt++;
            if (j == 4) stop = 1'b1;
        end
        checkOutput("post-reset valid count", v_cnt, 1);
        checkOutput("post-reset timeout count", t_cnt, 0);
        checkOutput("post-reset event cycle", ev_k, 5);
        checkOutput("post-reset delay_out", ev_d, 4);

        // Stop held high throughout: no stop edge, full-window timeout without counter wrap
        applyStimulus(1023, -1, 1026, 1'b1);
        checkOutput("maxwin valid count", g_valid_cnt, 0);
        checkOutput("maxwin timeout count", g_to_cnt, 1);
        checkOutput("maxwin event cycle", g_event_k, 1024);
        checkOutput("maxwin delay_out", int'(delay_out), 4);
        checkOutput("maxwin busy first cycle", g_busy_k1, 1);

`ifdef SIGNAL_DELAY_METER_AVG_EN
        begin
            int avg_d [5] = '{8, 12, 16, 20, 4};
            int avg_v [5] = '{0, 0, 0, 1, 1};
            int avg_e [5] = '{0, 0, 0, 14, 13};
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            checkOutput("avg reset avg_out", int'(avg_out), 0);
            for (int i = 0; i < 5; i++) begin
                applyStimulus(100, avg_d[i], avg_d[i] + 4, 1'b0);
                checkOutput($sformatf("avg%0d delay_out", i), int'(delay_out), avg_d[i]);
                checkOutput($sformatf("avg%0d avg_valid count", i), g_avgv_cnt, avg_v[i]);
                checkOutput($sformatf("avg%0d avg_out", i), int'(avg_out), avg_e[i]);
                if (avg_v[i] != 0)
                    checkOutput($sformatf("avg%0d avg_valid cycle", i), g_avgv_k, avg_d[i] + 2);
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
